// File: rtl/alu_pkg.sv
// alu_pkg: opcode map, FSM encoding and flag grouping shared by the multi-cycle ALU.
package alu_pkg;
    localparam logic [3:0] OP_ADD = 4'd0;
    localparam logic [3:0] OP_SUB = 4'd1;
    localparam logic [3:0] OP_AND = 4'd2;
    localparam logic [3:0] OP_OR  = 4'd3;
    localparam logic [3:0] OP_XOR = 4'd4;
    localparam logic [3:0] OP_SLL = 4'd5;
    localparam logic [3:0] OP_SRL = 4'd6;
    localparam logic [3:0] OP_NOR = 4'd7;
    localparam logic [3:0] OP_MUL = 4'd8;
    localparam logic [3:0] OP_SLT = 4'd9;
    localparam logic [3:0] OP_SRA = 4'd10;

    typedef enum logic {ST_IDLE, ST_MUL} state_t;

    typedef struct packed {
        logic cout;
        logic ovf;
        logic err;
    } flags_t;
endpackage

// File: rtl/alu_mul_seq.sv
// alu_mul_seq: iterative shift-add unsigned multiplier, one partial product per cycle.
module alu_mul_seq #(
    parameter int DATA_WIDTH = 16
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      start,
    input  logic [DATA_WIDTH-1:0]     a,
    input  logic [DATA_WIDTH-1:0]     b,
    output logic                      busy,
    output logic                      last,
    output logic [2*DATA_WIDTH-1:0]   product
);
    localparam int CW = $clog2(DATA_WIDTH);

    logic [2*DATA_WIDTH-1:0] mcand;
    logic [2*DATA_WIDTH-1:0] acc;
    logic [DATA_WIDTH-1:0]   mplier;
    logic [CW-1:0]           cnt;

    assign last = busy && (cnt == CW'(DATA_WIDTH - 1));
    // product already includes the current iteration so the last cycle can be registered directly
    assign product = acc + (mplier[0] ? mcand : '0);

    always_ff @(posedge clk) begin
        if (rst) begin
            busy   <= 1'b0;
            cnt    <= '0;
            acc    <= '0;
            mcand  <= '0;
            mplier <= '0;
        end else if (start) begin
            busy   <= 1'b1;
            cnt    <= '0;
            acc    <= '0;
            mcand  <= {{DATA_WIDTH{1'b0}}, a};
            mplier <= b;
        end else if (busy) begin
            acc    <= product;
            mcand  <= mcand << 1;
            mplier <= mplier >> 1;
            cnt    <= last ? '0 : cnt + 1'b1;
            busy   <= !last;
        end
    end
endmodule

// File: rtl/alu_mc.sv
// alu_mc: multi-cycle ALU with valid/ready input, registered result and status flags.
module alu_mc
    import alu_pkg::*;
#(
    parameter int DATA_WIDTH = 16,
    parameter int OP_SIZE    = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DATA_WIDTH-1:0] rega,
    input  logic [DATA_WIDTH-1:0] regb,
    input  logic [OP_SIZE-1:0]    control,
    output logic                  out_valid,
    output logic [DATA_WIDTH-1:0] out_alu,
    output logic                  cout,
    output logic                  ovf,
    output logic                  zero,
    output logic                  neg,
    output logic                  err
);
    localparam int W = DATA_WIDTH;

    state_t              state, state_next;
    logic                accept, is_mul, mul_busy, mul_last, big;
    logic [2*W-1:0]      product;
    logic [W:0]          sum, diff;
    logic [W-1:0]        res;
    flags_t              fl;

    assign in_ready = (state == ST_IDLE);
    assign accept   = in_valid && in_ready;
    assign is_mul   = (control == OP_MUL);
    assign zero     = (out_alu == '0);
    assign neg      = out_alu[W-1];

    alu_mul_seq #(.DATA_WIDTH(W)) u_mul (
        .clk     (clk),
        .rst     (rst),
        .start   (accept && is_mul),
        .a       (rega),
        .b       (regb),
        .busy    (mul_busy),
        .last    (mul_last),
        .product (product)
    );

    always_comb begin
        state_next = state;
        if (state == ST_IDLE)
            state_next = (accept && is_mul) ? ST_MUL : ST_IDLE;
        else
            state_next = (mul_last || !mul_busy) ? ST_IDLE : ST_MUL;
    end

    always_comb begin
        sum  = {1'b0, rega} + {1'b0, regb};
        diff = {1'b0, rega} - {1'b0, regb};
        big  = regb >= W'(W);
        res  = '0;
        fl   = '0;
        case (control)
            OP_ADD: begin
                res     = sum[W-1:0];
                fl.cout = sum[W];
                fl.ovf  = (rega[W-1] == regb[W-1]) && (sum[W-1] != rega[W-1]);
            end
            OP_SUB: begin
                res     = diff[W-1:0];
                fl.cout = diff[W];
                fl.ovf  = (rega[W-1] != regb[W-1]) && (diff[W-1] != rega[W-1]);
            end
            OP_AND: res = rega & regb;
            OP_OR:  res = rega | regb;
            OP_XOR: res = rega ^ regb;
            OP_NOR: res = ~(rega | regb);
            OP_SLL: res = big ? '0 : rega << regb;
            OP_SRL: res = big ? '0 : rega >> regb;
            OP_SRA: res = big ? {W{rega[W-1]}} : $unsigned($signed(rega) >>> regb);
            OP_SLT: res = W'($signed(rega) < $signed(regb));
            OP_MUL: res = '0;
            default: fl.err = 1'b1;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_IDLE;
            out_valid <= 1'b0;
            out_alu   <= '0;
            cout      <= 1'b0;
            ovf       <= 1'b0;
            err       <= 1'b0;
        end else begin
            state     <= state_next;
            out_valid <= (accept && !is_mul) || mul_last;
            if (accept && !is_mul) begin
                out_alu <= res;
                cout    <= fl.cout;
                ovf     <= fl.ovf;
                err     <= fl.err;
            end else if (mul_last) begin
                out_alu <= product[W-1:0];
                cout    <= |product[2*W-1:W];
                ovf     <= 1'b0;
                err     <= 1'b0;
            end
        end
    end
endmodule

// File: doc/alu_mc.md
# alu_mc

Multi-cycle, parametrised successor to the processor's combinational ALU. It accepts one operation per cycle through a valid/ready handshake and returns a registered result with status flags. Single-cycle operations complete in 1 cycle; an iterative multiply takes DATA_WIDTH cycles. It sits in the execute stage of the MIPS datapath, between the register-file read ports and the writeback mux.

## Interface
- DATA_WIDTH, 16: operand and result width, ≥ 4.
- OP_SIZE, 4: opcode width, fixed at 4 for this opcode map.
- clk  in  1: single clock; all state updates on the rising edge.
- rst  in  1: synchronous, active-high reset.
- in_valid  in  1: operands and opcode are valid this cycle.
- in_ready  out  1: block can accept; high in IDLE only.
- rega  in  DATA_WIDTH: operand A.
- regb  in  DATA_WIDTH: operand B; full value is the shift amount for shifts.
- control  in  OP_SIZE: opcode.
- out_valid  out  1: one-cycle pulse; result and flags are valid.
- out_alu  out  DATA_WIDTH: result.
- cout  out  1: carry/borrow/multiply-overflow.
- ovf  out  1: signed overflow.
- zero  out  1: out_alu == 0.
- neg  out  1: out_alu[DATA_WIDTH-1].
- err  out  1: illegal opcode, valid with out_valid.

## Operation
- Opcodes: 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 SLL, 6 SRL, 7 NOR, 8 MUL (unsigned, low half), 9 SLT (signed A<B → 1, else 0), 10 SRA. Opcodes 11–15 are illegal.
- Accept: the block accepts an operation when in_valid && in_ready at a rising edge. Operands are captured, so inputs may change afterwards.
- Single-cycle ops (everything except MUL): the result is registered at the accept edge. in_ready stays high, giving back-to-back throughput of 1 operation per cycle.
- MUL: FSM goes IDLE → MUL. The shift-add iterates DATA_WIDTH times with a counter running 0..DATA_WIDTH-1. On the last iteration it registers the result and returns to IDLE.
- States: IDLE and MUL only. in_ready = (state == IDLE). in_valid during MUL is ignored and not queued.
- cout:
  - ADD: bit DATA_WIDTH of the (DATA_WIDTH+1)-bit sum.
  - SUB: borrow, i.e. 1 when rega < regb unsigned.
  - MUL: 1 when the upper half of the 2·DATA_WIDTH product is nonzero.
  - All other ops: 0.
- ovf: signed overflow for ADD and SUB; 0 for every other op.
- Shifts:
  - An amount ≥ DATA_WIDTH gives 0 for SLL and SRL.
  - An amount ≥ DATA_WIDTH gives all copies of the sign bit for SRA.
- Illegal opcode: completes as a single-cycle op with out_alu = 0, zero = 1, cout = ovf = neg = 0, err = 1.
- out_alu and flags hold their last value between out_valid pulses.

## Timing
- Reset values: state IDLE, in_ready 1, out_valid 0, out_alu 0, cout/ovf/neg/err 0, zero 1, counter 0.
- Single-cycle op accepted at edge k: out_valid is high for the cycle following edge k.
- MUL accepted at edge k:
  - in_ready is low from edge k to edge k+DATA_WIDTH.
  - At edge k+DATA_WIDTH, out_valid and in_ready both go high together.
  - A new operation can be accepted at edge k+DATA_WIDTH+1. Latency is 16 cycles at the default width.
- Reset has priority over every event, including a MUL in progress. The operation is aborted, no out_valid is produced, and the block is back in IDLE after the reset edge.
- Asserting in_valid in the same cycle as rst: the operation is not accepted.

## Structure
- Shared package alu_pkg holds:
  - opcode localparams OP_ADD … OP_SRA;
  - the FSM state encoding (ST_IDLE, ST_MUL);
  - a flag struct or grouped constants used by datapath decode.
- One sub-module, alu_mul_seq: iterative shift-add multiplier with start, busy, last, product[2·DATA_WIDTH-1:0]. The top level owns the handshake, the single-cycle datapath and flag generation.

## Test plan
- ADD 0xFFFF + 0x0001 → out_alu 0x0000, cout 1, zero 1, ovf 0, out_valid one cycle after accept.
- SUB 0x8000 − 0x0001 → 0x7FFF, ovf 1, cout 0. Then SUB 0x0001 − 0x0002 → 0xFFFF, cout 1, neg 1.
- Back-to-back stream, one op per cycle: XOR 0x00FF^0x0F0F, SRA 0x8000 by 3, SLL 0x0001 by 20 → 0x0FF0, 0xF000, 0x0000 on consecutive cycles with in_ready high throughout.
- MUL 0x0100 × 0x0100 → in_ready low 16 cycles, then 0x0000 with cout 1. MUL 0x00FF × 0x0003 → 0x02FD, cout 0. in_valid asserted mid-multiply is ignored.
- rst pulsed 5 cycles into a MUL → no out_valid, outputs return to reset values, and a following ADD 2+3 → 0x0005.
- Opcode 12 → err 1, out_alu 0, zero 1, single-cycle latency. SLT 0xFFFF vs 0x0001 → 0x0001.
